spi_fpga_slave: RTL and testbench

- SPI slave front end that deserializes host SPI frames in the I_clk domain.
- Drives the addressed FPGA register file: enable, write strobe, address and write data. Returns read data from that register file on SDO.
- Uses the ADI frame format: 16-bit instruction, then 1–3 data bytes or streaming, MSB first, address auto-decrement.
- Sits directly upstream of the register-map block. Its O_enable falling edge marks end of frame for the registered outputs.

---
 rtl/spi_fpga_slave.sv | 157 +++++++++++++++
 tb/tb_spi_fpga_slave.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_fpga_slave.sv
// SPI slave front end (ADI frame format) driving an FPGA register file.
// Optional `SPI_3WIRE_EN selects 3-wire SDIO output-enable behaviour.
module spi_fpga_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned INSTR_BITS  = 16
) (
  input  logic       I_clk,
  input  logic       I_reset,
  input  logic       I_sclk,
  input  logic       I_csb,
  input  logic       I_sdi,
  input  logic [7:0] I_dout,
  output logic       O_sdo,
  output logic       O_sdo_oe,
  output logic       O_enable,
  output logic       O_wen,
  output logic [7:0] O_addr,
  output logic [7:0] O_din
);

  localparam int unsigned BCW = $clog2(INSTR_BITS);

  typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_e;

  // Synchronizers carry no reset so a mid-frame reset cannot fabricate a CSB edge.
  logic [SYNC_STAGES-1:0] sclk_sync_q, csb_sync_q, sdi_sync_q;
  logic                   sclk_prev_q, csb_prev_q;

  always_ff @(posedge I_clk) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], I_sclk};
    csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], I_csb};
    sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], I_sdi};
    sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    csb_prev_q  <= csb_sync_q[SYNC_STAGES-1];
  end

  logic sclk_s, csb_s, sdi_s;
  logic sclk_rise, sclk_fall, csb_rise, csb_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csb_rise  = csb_s & ~csb_prev_q;
  assign csb_fall  = ~csb_s & csb_prev_q;

  state_e                state_q;
  logic [BCW-1:0]        bitcnt_q;
  logic [INSTR_BITS-2:0] instr_q;
  logic [INSTR_BITS-1:0] instr_d;
  logic                  rw_q, stream_q, load_q, dec_q, wen_q;
  logic [1:0]            cnt_q;
  logic [7:0]            rd_sh_q, addr_q, din_q;

  always_comb begin
    instr_d = {instr_q, sdi_s};
  end

  // cnt_q holds bytes remaining minus one; streaming frames never exhaust it.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      instr_q  <= '0;
      rw_q     <= 1'b0;
      stream_q <= 1'b0;
      cnt_q    <= '0;
      rd_sh_q  <= '0;
      load_q   <= 1'b0;
      dec_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      wen_q  <= 1'b0;
      load_q <= 1'b0;
      dec_q  <= 1'b0;
      if (csb_rise) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (csb_fall) begin
              state_q  <= INSTR;
              bitcnt_q <= '0;
            end
          end
          INSTR: begin
            if (sclk_rise) begin
              instr_q <= instr_d[INSTR_BITS-2:0];
              if (bitcnt_q == BCW'(INSTR_BITS - 1)) begin
                rw_q     <= instr_d[15];
                stream_q <= &instr_d[14:13];
                cnt_q    <= instr_d[14:13];
                addr_q   <= instr_d[7:0];
                load_q   <= instr_d[15];
                rd_sh_q  <= '0;
                bitcnt_q <= '0;
                state_q  <= DATA;
              end else begin
                bitcnt_q <= bitcnt_q + 1'b1;
              end
            end
          end
          DATA: begin
            // The first fall of a byte follows the boundary rise, so it must not shift.
            if (load_q)
              rd_sh_q <= I_dout;
            else if (sclk_fall && rw_q && bitcnt_q != '0)
              rd_sh_q <= {rd_sh_q[6:0], 1'b0};
            if (dec_q) begin
              addr_q <= addr_q - 8'd1;
              if (!stream_q && cnt_q == 2'd0) state_q <= DONE;
              else if (!stream_q)             cnt_q   <= cnt_q - 2'd1;
            end
            if (sclk_rise) begin
              instr_q <= instr_d[INSTR_BITS-2:0];
              if (bitcnt_q == BCW'(7)) begin
                bitcnt_q <= '0;
                if (rw_q) begin
                  addr_q <= addr_q - 8'd1;
                  if (!stream_q && cnt_q == 2'd0) begin
                    state_q <= DONE;
                  end else begin
                    load_q <= 1'b1;
                    if (!stream_q) cnt_q <= cnt_q - 2'd1;
                  end
                end else begin
                  din_q <= instr_d[7:0];
                  wen_q <= 1'b1;
                  dec_q <= 1'b1;
                end
              end else begin
                bitcnt_q <= bitcnt_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign O_enable = (state_q != IDLE);
  assign O_sdo    = (state_q == DATA) && rw_q && rd_sh_q[7];
  assign O_wen    = wen_q;
  assign O_addr   = addr_q;
  assign O_din    = din_q;

`ifdef SPI_3WIRE_EN
  assign O_sdo_oe = (state_q == DATA) && rw_q;
`else
  assign O_sdo_oe = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_spi_fpga_slave.sv
// Self-checking bench for spi_fpga_slave: frame table plus hand-written corner cases.
module tb_spi_fpga_slave;
  localparam int unsigned SS = 2;

`ifdef SPI_3WIRE_EN
  localparam logic OE_INSTR = 1'b0, OE_WR = 1'b0, OE_RD_DONE = 1'b0;
`else
  localparam logic OE_INSTR = 1'b1, OE_WR = 1'b1, OE_RD_DONE = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst, sclk, csb, sdi;
  logic [7:0] dout;
  logic       sdo, sdo_oe, en, wen;
  logic [7:0] addr, din;

  always #5 clk = ~clk;

  spi_fpga_slave #(.SYNC_STAGES(SS), .INSTR_BITS(16)) dut (
    .I_clk(clk), .I_reset(rst), .I_sclk(sclk), .I_csb(csb), .I_sdi(sdi),
    .I_dout(dout), .O_sdo(sdo), .O_sdo_oe(sdo_oe), .O_enable(en),
    .O_wen(wen), .O_addr(addr), .O_din(din)
  );

  logic [7:0] mem [256];
  assign dout = mem[addr];

  int tests = 0;
  int fails = 0;
  logic [15:0] wq[$];
  logic        rq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write scoreboard: every O_wen cycle must match the next expected {addr,din}.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      if (wq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wen: got addr=%h din=%h expected no write", addr, din);
      end else begin
        check("wen_addr_din", {16'h0, addr, din}, {16'h0, wq.pop_front()});
      end
    end
  end

  task automatic bit_x(input logic b, input bit smp);
    sdi = b;
    #80;
    if (smp) begin
      if (rq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sdo_queue: got sample %b expected no sample", sdo);
      end else begin
        check("sdo_bit", {31'h0, sdo}, {31'h0, rq.pop_front()});
      end
    end
    sclk = 1'b1;
    #80;
    sclk = 1'b0;
  endtask

  task automatic byte_x(input logic [7:0] b, input bit smp);
    for (int i = 7; i >= 0; i--) bit_x(b[i], smp);
  endtask

  task automatic csb_high;
    int n;
    #80;
    csb = 1'b1;
    n = 0;
    while (n < int'(SS) + 2 && en !== 1'b0) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("enable_fall", {31'h0, en}, 32'h0);
    @(negedge clk);
    #160;
  endtask

  typedef struct {
    logic [15:0]      instr;
    int               nb;
    logic [3:0][7:0]  d;
    int               exp_n;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[6] = 8'h3C;

    vecs[0] = '{16'h0006, 1, 32'h000000A5, 1};
    vecs[1] = '{16'h4002, 4, 32'h44332211, 3};
    vecs[2] = '{16'h6001, 3, 32'h00CCBBAA, 3};
    vecs[3] = '{16'h3F10, 2, 32'h00005A69, 2};
    vecs[4] = '{16'h8006, 1, 32'h0, 1};
    vecs[5] = '{16'hA005, 3, 32'h0, 2};
    vecs[6] = '{16'hE000, 2, 32'h0, 2};

    rst = 1'b1; sclk = 1'b0; csb = 1'b1; sdi = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {26'h0, sdo, sdo_oe, en, wen, addr, din}, 32'h0);
    #160;
    check("idle_enable", {31'h0, en}, 32'h0);

    for (int v = 0; v < 7; v++) begin
      logic [7:0] a;
      a = vecs[v].instr[7:0];
      csb = 1'b0;
      byte_x(vecs[v].instr[15:8], 1'b0);
      check("oe_instr", {31'h0, sdo_oe}, {31'h0, OE_INSTR});
      byte_x(vecs[v].instr[7:0], 1'b0);
      for (int i = 0; i < vecs[v].nb; i++) begin
        logic [7:0] ea;
        ea = 8'(a - 8'(i));
        if (!vecs[v].instr[15]) begin
          if (i < vecs[v].exp_n) wq.push_back({ea, vecs[v].d[i]});
          byte_x(vecs[v].d[i], 1'b0);
          if (i == 0) check("oe_write", {31'h0, sdo_oe}, {31'h0, OE_WR});
        end else begin
          check("oe_read", {31'h0, sdo_oe},
                {31'h0, (i < vecs[v].exp_n) ? 1'b1 : OE_RD_DONE});
          for (int k = 7; k >= 0; k--)
            rq.push_back((i < vecs[v].exp_n) ? mem[ea][k] : 1'b0);
          byte_x(8'h00, 1'b1);
        end
      end
      csb_high();
    end

    // Abort after 5 data bits: no write, then a clean frame.
    csb = 1'b0;
    byte_x(8'h00, 1'b0);
    byte_x(8'h20, 1'b0);
    for (int i = 0; i < 5; i++) bit_x(1'b1, 1'b0);
    csb_high();
    csb = 1'b0;
    wq.push_back({8'h42, 8'h5A});
    byte_x(8'h00, 1'b0);
    byte_x(8'h42, 1'b0);
    byte_x(8'h5A, 1'b0);
    csb_high();
    check("addr_after_write", {24'h0, addr}, 32'h41);

    // One-cycle reset mid-instruction; remaining edges must be ignored.
    csb = 1'b0;
    for (int i = 0; i < 6; i++) bit_x(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_outputs", {26'h0, sdo, sdo_oe, en, wen, addr, din}, 32'h0);
    for (int i = 0; i < 2; i++) bit_x(1'b0, 1'b0);
    byte_x(8'h33, 1'b0);
    byte_x(8'h77, 1'b0);
    check("midreset_ignored", {31'h0, en}, 32'h0);
    csb_high();
    csb = 1'b0;
    wq.push_back({8'h33, 8'h77});
    byte_x(8'h00, 1'b0);
    byte_x(8'h33, 1'b0);
    byte_x(8'h77, 1'b0);
    csb_high();

    #200;
    check("wq_drained", wq.size(), 32'h0);
    check("rq_drained", rq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
